hazard_unit: RTL and testbench

Pipeline hazard unit for the five-stage MIPS core. It generates the `stall` input of the control unit. Each cycle it decodes the instruction sitting in ID to find its source-register usage, and tracks the destinations of older instructions in shadow EX/MEM/WB registers. From that it drives PC/IF-ID hold, IF/ID and ID/EX flush, and a bubble request into the control unit. It sits beside the ID stage, alongside the control unit, and also keeps a saturating stall-cycle counter for performance checks.

---
 rtl/hazard_unit_pkg.sv | 51 +++++
 rtl/reg_use_decode.sv | 62 ++++++
 rtl/hazard_unit.sv | 124 ++++++++++++
 tb/tb_hazard_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// Package: mips_defs
// Shared definitions for the five-stage MIPS core: opcode and funct
// encodings (also used by the control unit), register-index width, the
// shadow-pipeline entry layout and the per-instruction register-use record.
package mips_defs;

   localparam int REG_W = 5;

   // Primary opcodes (instr[31:26])
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ANDI  = 6'h0c;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_XORI  = 6'h0e;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;

   // R-type funct codes (instr[5:0]) that read rs/rt and write rd
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2a;

   // One shadow-pipeline entry: an older instruction's pending write
   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] dst;
      logic             memread;
   } shadow_t;

   // Register usage of the instruction sitting in ID
   typedef struct packed {
      logic             rs_used;
      logic             rt_used;
      logic [REG_W-1:0] rs;
      logic [REG_W-1:0] rt;
      logic             wr;
      logic [REG_W-1:0] dst;
      logic             memread;
      logic             jump;
   } reg_use_t;

   // ALU R-type group: add..nor (0x20-0x27) plus slt
   function automatic logic is_alu_funct(input logic [5:0] fn);
      return ((fn >= FN_ADD) && (fn <= FN_NOR)) || (fn == FN_SLT);
   endfunction

endpackage

// File: rtl/reg_use_decode.sv
// Module: reg_use_decode
// Combinational decode of one instruction word into its register usage.
// Ports:
//   instr  in   32-bit instruction word
//   ru     out  {rs_used, rt_used, rs, rt, wr, dst, memread, jump}
// Encodings not listed below decode as a nop (no reads, no write).
module reg_use_decode
   import mips_defs::*;
(
   input  logic [31:0] instr,
   output reg_use_t    ru
);

   logic [5:0] opcode;
   logic [5:0] funct;
   logic       unused_bits;

   assign opcode = instr[31:26];
   assign funct  = instr[5:0];

   // shamt never names a register; only sink it so it is visibly ignored
   assign unused_bits = ^instr[10:6];

   always_comb begin
      // NOTE: every field gets a default first so no path leaves a latch.
      ru         = '0;
      ru.rs      = instr[25:21];
      ru.rt      = instr[20:16];
      case (opcode)
         OP_RTYPE: begin
            if (is_alu_funct(funct)) begin
               ru.rs_used = 1'b1;
               ru.rt_used = 1'b1;
               ru.wr      = 1'b1;
               ru.dst     = instr[15:11];
            end
         end
         OP_BEQ, OP_BNE, OP_SW: begin
            ru.rs_used = 1'b1;
            ru.rt_used = 1'b1;
         end
         OP_LW: begin
            ru.rs_used = 1'b1;
            ru.wr      = 1'b1;
            ru.dst     = instr[20:16];
            ru.memread = 1'b1;
         end
         OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: begin
            ru.rs_used = 1'b1;
            ru.wr      = 1'b1;
            ru.dst     = instr[20:16];
         end
         OP_J: ru.jump = 1'b1;
         default: ;
      endcase
      // $0 is hard-wired, so a write to it can never create a dependency
      if (ru.dst == '0) begin
         ru.wr = 1'b0;
      end
   end

endmodule

// File: rtl/hazard_unit.sv
// Module: hazard_unit
// Pipeline hazard unit beside the ID stage. Tracks the destinations of the
// instructions in EX/MEM/WB with a shadow pipeline, detects RAW hazards for
// the instruction in ID and drives hold/flush/bubble controls. Also keeps a
// saturating count of hazard-stall cycles.
// Parameters:
//   FORWARDING  1: EX/MEM forwarding exists, only load-use stalls
//               0: stall on any RAW hazard against EX or MEM
//   CNT_W       width of stall_cycles
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   if_id_instr       instruction in ID
//   ex_branch_taken   branch in EX resolved taken
//   stall             bubble request to the control unit
//   pc_write          0 holds PC
//   if_id_write       0 holds IF/ID
//   if_id_flush       zero IF/ID on next edge
//   id_ex_flush       bubble ID/EX on next edge
//   stall_cycles      saturating hazard-stall cycle count
module hazard_unit
   import mips_defs::*;
#(
   parameter bit FORWARDING = 1'b1,
   parameter int CNT_W      = 16
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      if_id_instr,
   input  logic             ex_branch_taken,
   output logic             stall,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic [CNT_W-1:0] stall_cycles
);

   reg_use_t id_use;
   shadow_t  ex_q, mem_q, wb_q;
   shadow_t  ex_d;
   logic     hz;
   logic     unused_wb;

   reg_use_decode u_decode (
      .instr (if_id_instr),
      .ru    (id_use)
   );

   // True when stage entry e produces a register the ID instruction reads.
   // need_load restricts the match to loads (the only case forwarding
   // cannot cover).
   function automatic logic hits(input shadow_t e, input reg_use_t u,
                                 input logic need_load);
      logic match;
      match = (u.rs_used && (u.rs == e.dst)) || (u.rt_used && (u.rt == e.dst));
      return e.valid && match && (e.memread || !need_load);
   endfunction

   always_comb begin
      if (FORWARDING) begin
         hz = hits(ex_q, id_use, 1'b1);
      end else begin
         hz = hits(ex_q, id_use, 1'b0) || hits(mem_q, id_use, 1'b0);
      end
   end

   // Priority: reset / branch squash, then hazard hold, then jump flush
   always_comb begin
      stall       = 1'b0;
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      if (reset || ex_branch_taken) begin
         stall       = 1'b1;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (hz) begin
         stall       = 1'b1;
         pc_write    = 1'b0;
         if_id_write = 1'b0;
      end else if (id_use.jump) begin
         if_id_flush = 1'b1;
      end
   end

   // A bubble enters EX whenever the control unit is told to stall
   always_comb begin
      ex_d = '0;
      if (!stall) begin
         ex_d.valid   = id_use.wr;
         ex_d.dst     = id_use.dst;
         ex_d.memread = id_use.memread;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every stage
      // samples its predecessor's pre-edge value.
      if (reset) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= ex_q;
         wb_q  <= mem_q;
      end
   end

   // WB never hazards (write-first register file); its entry is kept for
   // pipeline visibility only.
   assign unused_wb = ^wb_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles <= '0;
      end else if (hz && !ex_branch_taken && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_unit.sv
// Testbench for hazard_unit. Two instances share the stimulus: one with
// forwarding (16-bit counter) and one without (4-bit counter, so saturation
// is reached). A behavioural model tracks, per instance, the list of pending
// register writes by age and derives the expected controls each cycle.
module tb_hazard_unit;

   localparam logic [31:0] NOP  = 32'h0000_0000;
   localparam logic [31:0] LW8  = 32'h8D28_0000;  // lw   $8,0($9)
   localparam logic [31:0] ADD8 = 32'h010B_5020;  // add  $10,$8,$11
   localparam logic [31:0] ADDI = 32'h2008_0005;  // addi $8,$0,5
   localparam logic [31:0] LW0  = 32'h8D20_0000;  // lw   $0,0($9)
   localparam logic [31:0] ADD0 = 32'h000B_5020;  // add  $10,$0,$11
   localparam logic [31:0] JMP  = 32'h0800_0040;  // j    0x100

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] if_id_instr;
   logic        ex_branch_taken;

   logic        stall_f, pc_write_f, if_id_write_f, if_id_flush_f, id_ex_flush_f;
   logic [15:0] stall_cycles_f;
   logic        stall_n, pc_write_n, if_id_write_n, if_id_flush_n, id_ex_flush_n;
   logic [3:0]  stall_cycles_n;

   always #5 clk = ~clk;

   hazard_unit #(.FORWARDING(1'b1), .CNT_W(16)) dut_f (
      .clk             (clk),
      .reset           (reset),
      .if_id_instr     (if_id_instr),
      .ex_branch_taken (ex_branch_taken),
      .stall           (stall_f),
      .pc_write        (pc_write_f),
      .if_id_write     (if_id_write_f),
      .if_id_flush     (if_id_flush_f),
      .id_ex_flush     (id_ex_flush_f),
      .stall_cycles    (stall_cycles_f)
   );

   hazard_unit #(.FORWARDING(1'b0), .CNT_W(4)) dut_n (
      .clk             (clk),
      .reset           (reset),
      .if_id_instr     (if_id_instr),
      .ex_branch_taken (ex_branch_taken),
      .stall           (stall_n),
      .pc_write        (pc_write_n),
      .if_id_write     (if_id_write_n),
      .if_id_flush     (if_id_flush_n),
      .id_ex_flush     (id_ex_flush_n),
      .stall_cycles    (stall_cycles_n)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // pend_dst[c][0] = destination of the instruction one slot ahead (EX),
   // pend_dst[c][1] = two slots ahead (MEM); -1 means no pending write.
   int  pend_dst [2][2];
   bit  pend_ld  [2][2];
   int  cnt      [2];
   int  cmax     [2] = '{65535, 15};
   bit  known    = 1'b0;
   bit  m_hz     [2];
   bit  m_stall  [2];
   int  m_dst;
   bit  m_ld;
   bit  cur_rst, cur_br;

   function automatic void model_decode(input logic [31:0] w,
                                        output int r0, output int r1,
                                        output int dst, output bit ld,
                                        output bit jmp);
      logic [5:0] op, fn;
      op  = w[31:26];
      fn  = w[5:0];
      r0  = -1; r1 = -1; dst = -1; ld = 1'b0; jmp = 1'b0;
      if (op == 6'h00 && ((fn >= 6'h20 && fn <= 6'h27) || fn == 6'h2a)) begin
         r0 = int'(w[25:21]); r1 = int'(w[20:16]); dst = int'(w[15:11]);
      end else if (op inside {6'h04, 6'h05, 6'h2b}) begin
         r0 = int'(w[25:21]); r1 = int'(w[20:16]);
      end else if (op == 6'h23) begin
         r0 = int'(w[25:21]); dst = int'(w[20:16]); ld = 1'b1;
      end else if (op inside {6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0e}) begin
         r0 = int'(w[25:21]); dst = int'(w[20:16]);
      end else if (op == 6'h02) begin
         jmp = 1'b1;
      end
      if (dst == 0) dst = -1;
   endfunction

   // Apply inputs, let logic settle, compare both instances to the model
   task automatic drive(input logic [31:0] w, input bit br, input bit rst);
      int r0, r1, dst;
      bit ld, jmp, hz;
      logic [4:0] exp_v, got_v;
      if_id_instr     = w;
      ex_branch_taken = br;
      reset           = rst;
      cur_rst         = rst;
      cur_br          = br;
      #2;
      model_decode(w, r0, r1, dst, ld, jmp);
      m_dst = dst;
      m_ld  = ld;
      for (int c = 0; c < 2; c++) begin
         hz = 1'b0;
         foreach (pend_dst[c][a]) begin
            if (c == 0 && a == 1) continue;       // forwarding covers MEM
            if (c == 0 && !pend_ld[c][a]) continue; // forwarding covers ALU
            if ((r0 >= 0 && r0 == pend_dst[c][a]) ||
                (r1 >= 0 && r1 == pend_dst[c][a])) hz = 1'b1;
         end
         // {stall, pc_write, if_id_write, if_id_flush, id_ex_flush}
         if (rst || br)   exp_v = 5'b11111;
         else if (hz)     exp_v = 5'b10000;
         else if (jmp)    exp_v = 5'b01110;
         else             exp_v = 5'b01100;
         m_hz[c]    = hz && !rst;
         m_stall[c] = exp_v[4];
         if (c == 0) begin
            got_v = {stall_f, pc_write_f, if_id_write_f, if_id_flush_f, id_ex_flush_f};
            check("ctl_fwd", 32'(got_v), 32'(exp_v));
            if (known) check("cnt_fwd", 32'(stall_cycles_f), cnt[0]);
         end else begin
            got_v = {stall_n, pc_write_n, if_id_write_n, if_id_flush_n, id_ex_flush_n};
            check("ctl_nofwd", 32'(got_v), 32'(exp_v));
            if (known) check("cnt_nofwd", 32'(stall_cycles_n), cnt[1]);
         end
      end
   endtask

   // Advance one clock edge and update the model with the pre-edge inputs
   task automatic tick();
      @(posedge clk);
      for (int c = 0; c < 2; c++) begin
         if (cur_rst) begin
            pend_dst[c][0] = -1; pend_dst[c][1] = -1;
            pend_ld[c][0]  = 1'b0; pend_ld[c][1] = 1'b0;
            cnt[c]         = 0;
         end else begin
            if (m_hz[c] && !cur_br && cnt[c] < cmax[c]) cnt[c]++;
            pend_dst[c][1] = pend_dst[c][0];
            pend_ld[c][1]  = pend_ld[c][0];
            pend_dst[c][0] = m_stall[c] ? -1 : m_dst;
            pend_ld[c][0]  = m_stall[c] ? 1'b0 : m_ld;
         end
      end
      if (cur_rst) known = 1'b1;
      #1;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [5:0] ops [14];
      logic [5:0] fns [11];
      logic [5:0] op, fn;
      ops = '{6'h00, 6'h00, 6'h04, 6'h05, 6'h2b, 6'h23, 6'h23,
              6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0e, 6'h02, 6'h3f};
      fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
              6'h27, 6'h2a, 6'h00, 6'h08};
      op = ops[$urandom_range(0, 13)];
      fn = fns[$urandom_range(0, 10)];
      return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), fn};
   endfunction

   initial begin
      reset = 1'b1; ex_branch_taken = 1'b0; if_id_instr = NOP;
      #1;

      // Load-use with forwarding: one-cycle hold
      drive(NOP, 0, 1);  tick();
      drive(LW8, 0, 0);  check("t1_pre", 32'(stall_f), 0); tick();
      drive(ADD8, 0, 0);
      check("t1_stall", 32'(stall_f), 1);
      check("t1_pc_hold", 32'(pc_write_f), 0);
      check("t1_ifid_hold", 32'(if_id_write_f), 0);
      tick();
      drive(ADD8, 0, 0);
      check("t1_release", 32'(stall_f), 0);
      check("t1_count", 32'(stall_cycles_f), 1);
      tick();

      // ALU dependency: two stalls without forwarding, none with
      drive(NOP, 0, 1);  tick();
      drive(ADDI, 0, 0); tick();
      drive(ADD8, 0, 0);
      check("t2_nofwd_s1", 32'(stall_n), 1);
      check("t2_fwd_free", 32'(stall_f), 0);
      tick();
      drive(ADD8, 0, 0); check("t2_nofwd_s2", 32'(stall_n), 1); tick();
      drive(ADD8, 0, 0);
      check("t2_nofwd_done", 32'(stall_n), 0);
      check("t2_nofwd_cnt", 32'(stall_cycles_n), 2);
      check("t2_fwd_cnt", 32'(stall_cycles_f), 0);
      tick();

      // $0 destination never creates a hazard
      drive(NOP, 0, 1);  tick();
      drive(LW0, 0, 0);  tick();
      drive(ADD0, 0, 0);
      check("t3_fwd", 32'(stall_f), 0);
      check("t3_nofwd", 32'(stall_n), 0);
      tick();

      // Branch squash overrides a load-use hazard and is not counted
      drive(NOP, 0, 1);  tick();
      drive(LW8, 0, 0);  tick();
      drive(ADD8, 1, 0);
      check("t4_ctl", 32'({stall_f, pc_write_f, if_id_flush_f, id_ex_flush_f}), 32'hF);
      tick();
      drive(NOP, 0, 0);  check("t4_cnt", 32'(stall_cycles_f), 0); tick();

      // Jump flushes IF/ID only
      drive(JMP, 0, 0);
      check("t5_ctl", 32'({if_id_flush_f, stall_f, id_ex_flush_f}), 32'h4);
      tick();
      drive(NOP, 0, 0);  check("t5_after", 32'(if_id_flush_f), 0); tick();

      // Taken branch with a jump in ID: branch wins
      drive(JMP, 1, 0);
      check("t5_br_wins", 32'({stall_f, id_ex_flush_f}), 32'h3);
      tick();

      // Reset during the load-use stall aborts it
      drive(NOP, 0, 1);  tick();
      drive(LW8, 0, 0);  tick();
      drive(ADD8, 0, 1);
      check("t6_rst_ctl", 32'({stall_f, pc_write_f, if_id_write_f,
                               if_id_flush_f, id_ex_flush_f}), 32'h1F);
      tick();
      drive(ADD8, 0, 0);
      check("t6_no_hz", 32'(stall_f), 0);
      check("t6_cnt", 32'(stall_cycles_f), 0);
      tick();

      // Randomized run against the model
      for (int i = 0; i < 3000; i++) begin
         drive(rand_instr(), ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 99) == 0));
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
